wb_burst_master: RTL and testbench

Wishbone classic (B3, single-beat-per-strobe) bus master that turns command-stream requests into one or more back-to-back Wishbone cycles against the SDRAM controller's Wishbone slave port. It is the initiator counterpart of the controller's `wb_*` slave interface. It holds `wb_cyc_o` for the whole burst, gates `wb_stb_o` per beat, and returns read data and a completion status. It sits between the test/traffic front-end and the `sdr_ctrl` Wishbone port, in the `wb_clk_i` domain.

---
 rtl/wb_burst_master.sv | 194 +++++++++++++++++++
 tb/tb_wb_burst_master.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_master.sv
// Wishbone classic burst master: turns one command into 1..2^LENW
// single-beat Wishbone transfers, holding CYC across the burst, and reports
// read data plus a per-burst completion status (ok / bus error / timeout).
module wb_burst_master #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int LENW        = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic            wb_clk_i,
  input  logic            resetn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [DW/8-1:0] cmd_sel,
  input  logic [LENW-1:0] cmd_len,
  input  logic            wd_valid,
  output logic            wd_ready,
  input  logic [DW-1:0]   wd_data,
  output logic            rd_valid,
  output logic [DW-1:0]   rd_data,
  output logic            done,
  output logic            done_err,
  output logic            done_tmo,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i
);

  localparam int SW = DW / 8;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_REQ, S_DONE} state_t;

  state_t          state, state_next;
  logic            live;
  logic [LENW-1:0] len_q, len_next;
  logic [LENW-1:0] beat_q, beat_next;
  logic [TW-1:0]   tmo_q, tmo_next;

  logic            cyc_next, stb_next, we_next;
  logic [AW-1:0]   adr_next;
  logic [DW-1:0]   dat_next;
  logic [SW-1:0]   sel_next;
  logic            rd_valid_next;
  logic [DW-1:0]   rd_data_next;
  logic            done_next, done_err_next, done_tmo_next;

  // Next word address; wraps naturally at the top of the address space.
  function automatic logic [AW-1:0] adr_step(input logic [AW-1:0] a);
    return a + AW'(SW);
  endfunction

  // A beat has waited its full budget when the counter sits one short of the limit.
  function automatic logic tmo_expired(input logic [TW-1:0] t);
    return t == TW'(TIMEOUT_CYC - 1);
  endfunction

  // cmd_ready stays low while in reset and until the first edge afterwards.
  assign cmd_ready = live && (state == S_IDLE);
  assign wd_ready  = (state == S_LOAD);

  // Next-state and next-output decode; registered outputs hold unless changed.
  always_comb begin
    state_next    = state;
    len_next      = len_q;
    beat_next     = beat_q;
    tmo_next      = tmo_q;
    cyc_next      = wb_cyc_o;
    stb_next      = wb_stb_o;
    we_next       = wb_we_o;
    adr_next      = wb_adr_o;
    dat_next      = wb_dat_o;
    sel_next      = wb_sel_o;
    rd_valid_next = 1'b0;
    rd_data_next  = rd_data;
    done_next     = 1'b0;
    done_err_next = 1'b0;
    done_tmo_next = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          adr_next  = cmd_addr;
          sel_next  = cmd_sel;
          we_next   = cmd_we;
          len_next  = cmd_len;
          beat_next = '0;
          tmo_next  = '0;
          cyc_next  = 1'b1;
          stb_next  = !cmd_we;
          state_next = cmd_we ? S_LOAD : S_REQ;
        end
      end
      S_LOAD: begin
        if (wd_valid) begin
          dat_next   = wd_data;
          stb_next   = 1'b1;
          tmo_next   = '0;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (wb_err_i) begin
          cyc_next      = 1'b0;
          stb_next      = 1'b0;
          done_next     = 1'b1;
          done_err_next = 1'b1;
          state_next    = S_DONE;
        end else if (wb_ack_i) begin
          if (!wb_we_o) begin
            rd_valid_next = 1'b1;
            rd_data_next  = wb_dat_i;
          end
          if (beat_q == len_q) begin
            cyc_next   = 1'b0;
            stb_next   = 1'b0;
            done_next  = 1'b1;
            state_next = S_DONE;
          end else begin
            adr_next  = adr_step(wb_adr_o);
            beat_next = beat_q + LENW'(1);
            tmo_next  = '0;
            if (wb_we_o) begin
              stb_next   = 1'b0;
              state_next = S_LOAD;
            end
          end
        end else if (tmo_expired(tmo_q)) begin
          cyc_next      = 1'b0;
          stb_next      = 1'b0;
          done_next     = 1'b1;
          done_err_next = 1'b1;
          done_tmo_next = 1'b1;
          state_next    = S_DONE;
        end else begin
          tmo_next = tmo_q + TW'(1);
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything without a done pulse.
  always_ff @(posedge wb_clk_i or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      live     <= 1'b0;
      len_q    <= '0;
      beat_q   <= '0;
      tmo_q    <= '0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      done     <= 1'b0;
      done_err <= 1'b0;
      done_tmo <= 1'b0;
    end else begin
      state    <= state_next;
      live     <= 1'b1;
      len_q    <= len_next;
      beat_q   <= beat_next;
      tmo_q    <= tmo_next;
      wb_cyc_o <= cyc_next;
      wb_stb_o <= stb_next;
      wb_we_o  <= we_next;
      wb_adr_o <= adr_next;
      wb_dat_o <= dat_next;
      wb_sel_o <= sel_next;
      rd_valid <= rd_valid_next;
      rd_data  <= rd_data_next;
      done     <= done_next;
      done_err <= done_err_next;
      done_tmo <= done_tmo_next;
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: a behavioural Wishbone slave with configurable
// wait states / error / silence, plus scoreboard queues for addresses,
// write data, read data and burst completion status.
module tb_wb_burst_master;

  localparam int AW = 32, DW = 32, LENW = 4, TMO = 8;

  logic            wb_clk_i = 1'b0;
  logic            resetn = 1'b1;
  logic            cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [AW-1:0]   cmd_addr = '0;
  logic [3:0]      cmd_sel = '0;
  logic [LENW-1:0] cmd_len = '0;
  logic            wd_valid = 1'b0;
  logic [DW-1:0]   wd_data = '0;
  logic            cmd_ready, wd_ready, rd_valid, done, done_err, done_tmo;
  logic [DW-1:0]   rd_data, wb_dat_o;
  logic            wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0]   wb_adr_o;
  logic [3:0]      wb_sel_o;
  logic [DW-1:0]   wb_dat_i = '0;
  logic            wb_ack_i = 1'b0, wb_err_i = 1'b0;

  wb_burst_master #(.AW(AW), .DW(DW), .LENW(LENW), .TIMEOUT_CYC(TMO)) dut (
    .wb_clk_i(wb_clk_i), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .done_err(done_err), .done_tmo(done_tmo),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  initial forever #5 wb_clk_i = ~wb_clk_i;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rdat(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Scoreboard queues: filled by the stimulus, drained by the monitor/slave.
  logic [31:0] adr_q[$];
  logic [31:0] wr_q[$];
  logic [31:0] rd_q[$];
  logic [2:0]  done_q[$];   // {done_err, done_tmo, rd_valid at done}

  // Slave configuration (written by stimulus only).
  int          ack_wait = 0;
  int          err_beat = 99;
  bit          no_resp = 1'b0;
  bit          fixed_en = 1'b0;
  logic [31:0] fixed_dat = '0;
  logic        exp_we = 1'b0;
  logic [3:0]  exp_sel = 4'hF;

  // Monitor counters (written by monitor only).
  int cyc_cnt = 0, stb_cnt = 0, cyc_rise = 0, stb_rise = 0;
  int rd_cnt = 0, done_cnt = 0, viol = 0;

  // Monitor and Wishbone slave, both evaluated on the falling edge.
  initial begin
    int  wcnt = 0;
    int  beat_idx = 0;
    logic prev_cyc = 1'b0, prev_stb = 1'b0;
    forever begin
      @(negedge wb_clk_i);
      if (!resetn) begin
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wcnt = 0; beat_idx = 0;
        prev_cyc = 1'b0; prev_stb = 1'b0;
      end else begin
        if (wb_cyc_o) cyc_cnt++;
        if (wb_stb_o) stb_cnt++;
        if (wb_cyc_o && !prev_cyc) cyc_rise++;
        if (wb_stb_o && !prev_stb) stb_rise++;
        if (wb_stb_o && !wb_cyc_o) viol++;
        prev_cyc = wb_cyc_o; prev_stb = wb_stb_o;
        if (rd_valid) begin
          rd_cnt++;
          if (rd_q.size() == 0) chk("rd_unexpected", 64'(rd_valid), 64'd0);
          else chk("rd_data", 64'(rd_data), 64'(rd_q.pop_front()));
        end
        if (done) begin
          done_cnt++;
          if (done_q.size() == 0) chk("done_unexpected", 64'(done), 64'd0);
          else chk("done_status", 64'({done_err, done_tmo, rd_valid}), 64'(done_q.pop_front()));
        end
        if (wb_cyc_o && wb_stb_o && !no_resp) begin
          if (wcnt == ack_wait) begin
            wb_ack_i = 1'b1;
            wb_err_i = (beat_idx == err_beat);
            wb_dat_i = fixed_en ? fixed_dat : rdat(wb_adr_o);
            if (adr_q.size() == 0) chk("adr_unexpected", 64'(wb_stb_o), 64'd0);
            else chk("adr", 64'(wb_adr_o), 64'(adr_q.pop_front()));
            chk("we", 64'(wb_we_o), 64'(exp_we));
            chk("sel", 64'(wb_sel_o), 64'(exp_sel));
            if (wb_we_o) begin
              if (wr_q.size() == 0) chk("wdat_unexpected", 64'(wb_we_o), 64'd0);
              else chk("wdat", 64'(wb_dat_o), 64'(wr_q.pop_front()));
            end
            beat_idx++;
            wcnt = 0;
          end else begin
            wb_ack_i = 1'b0; wb_err_i = 1'b0;
            wcnt++;
          end
        end else begin
          wb_ack_i = 1'b0; wb_err_i = 1'b0; wcnt = 0;
        end
        if (!wb_cyc_o) beat_idx = 0;
      end
    end
  end

  // Baselines for per-test deltas.
  int b_cyc, b_stb, b_cyc_r, b_stb_r, b_rd, b_done;

  task automatic snap();
    b_cyc = cyc_cnt; b_stb = stb_cnt; b_cyc_r = cyc_rise; b_stb_r = stb_rise;
    b_rd = rd_cnt; b_done = done_cnt;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [3:0] len);
    int n = 0;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_sel = sel; cmd_len = len;
    while (!cmd_ready && n < 50) begin @(negedge wb_clk_i); n++; end
    if (!cmd_ready) chk("cmd_accept", 64'(cmd_ready), 64'd1);
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
  endtask

  task automatic send_wd(input logic [31:0] d);
    int n = 0;
    wd_valid = 1'b1; wd_data = d;
    while (!wd_ready && n < 100) begin @(negedge wb_clk_i); n++; end
    if (!wd_ready) chk("wd_accept", 64'(wd_ready), 64'd1);
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt <= b_done && n < 300) begin @(negedge wb_clk_i); n++; end
    chk(tag, 64'(done_cnt > b_done), 64'd1);
    repeat (2) @(negedge wb_clk_i);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_adrq"}, 64'(adr_q.size()), 64'd0);
    chk({tag, "_rdq"}, 64'(rd_q.size()), 64'd0);
    chk({tag, "_wrq"}, 64'(wr_q.size()), 64'd0);
    chk({tag, "_doneq"}, 64'(done_q.size()), 64'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({cmd_ready, wd_ready, rd_valid, done, done_err, done_tmo,
                             wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 64'd0);
    chk({tag, "_adr"}, 64'(wb_adr_o), 64'd0);
    chk({tag, "_datw"}, 64'(wb_dat_o), 64'd0);
    chk({tag, "_datr"}, 64'(rd_data), 64'd0);
  endtask

  initial begin
    int base_done;
    // Power-on reset
    #2 resetn = 1'b0;
    #1 chk_outputs_zero("por");
    repeat (3) @(negedge wb_clk_i);
    resetn = 1'b1;
    #1 chk("ready_before_edge", 64'(cmd_ready), 64'd0);
    @(negedge wb_clk_i);
    chk("ready_after_edge", 64'(cmd_ready), 64'd1);

    // Single read with two wait states
    snap();
    ack_wait = 2; fixed_en = 1'b1; fixed_dat = 32'hDEADBEEF; exp_we = 1'b0; exp_sel = 4'hF;
    adr_q.push_back(32'h100); rd_q.push_back(32'hDEADBEEF); done_q.push_back(3'b001);
    issue(1'b0, 32'h100, 4'hF, 4'd0);
    wait_done("t1_done");
    chk("t1_stb_cycles", 64'(stb_cnt - b_stb), 64'd3);
    chk("t1_stb_windows", 64'(stb_rise - b_stb_r), 64'd1);
    chk("t1_rd_pulses", 64'(rd_cnt - b_rd), 64'd1);
    chk_empty("t1");
    fixed_en = 1'b0;

    // Read burst of 4, zero wait
    snap();
    ack_wait = 0;
    for (int k = 0; k < 4; k++) begin
      adr_q.push_back(32'(k * 4)); rd_q.push_back(rdat(32'(k * 4)));
    end
    done_q.push_back(3'b001);
    issue(1'b0, 32'h0, 4'hF, 4'd3);
    wait_done("t2_done");
    chk("t2_cyc_cycles", 64'(cyc_cnt - b_cyc), 64'd4);
    chk("t2_stb_cycles", 64'(stb_cnt - b_stb), 64'd4);
    chk("t2_stb_windows", 64'(stb_rise - b_stb_r), 64'd1);
    chk("t2_rd_pulses", 64'(rd_cnt - b_rd), 64'd4);
    chk_empty("t2");

    // Write burst of 3 with a 5-cycle stall before beat 2
    snap();
    exp_we = 1'b1; exp_sel = 4'hF;
    adr_q.push_back(32'h40); adr_q.push_back(32'h44); adr_q.push_back(32'h48);
    wr_q.push_back(32'h11); wr_q.push_back(32'h22); wr_q.push_back(32'h33);
    done_q.push_back(3'b000);
    issue(1'b1, 32'h40, 4'hF, 4'd2);
    send_wd(32'h11);
    repeat (5) @(negedge wb_clk_i);
    send_wd(32'h22);
    send_wd(32'h33);
    wait_done("t3_done");
    chk("t3_cyc_windows", 64'(cyc_rise - b_cyc_r), 64'd1);
    chk("t3_stb_cycles", 64'(stb_cnt - b_stb), 64'd3);
    chk("t3_stb_windows", 64'(stb_rise - b_stb_r), 64'd3);
    chk("t3_stall_gap", 64'(((cyc_cnt - b_cyc) - (stb_cnt - b_stb)) >= 5), 64'd1);
    chk_empty("t3");

    // Zero-wait write of 2 beats with data always offered: cyc for 2L cycles
    snap();
    exp_sel = 4'h3;
    adr_q.push_back(32'h80); adr_q.push_back(32'h84);
    wr_q.push_back(32'hAAAA5555); wr_q.push_back(32'h12345678);
    done_q.push_back(3'b000);
    issue(1'b1, 32'h80, 4'h3, 4'd1);
    send_wd(32'hAAAA5555);
    send_wd(32'h12345678);
    wait_done("t3b_done");
    chk("t3b_cyc_cycles", 64'(cyc_cnt - b_cyc), 64'd4);
    chk_empty("t3b");

    // Read burst of 8 with err+ack on beat 3
    snap();
    exp_we = 1'b0; exp_sel = 4'hF; err_beat = 2;
    adr_q.push_back(32'h300); adr_q.push_back(32'h304); adr_q.push_back(32'h308);
    rd_q.push_back(rdat(32'h300)); rd_q.push_back(rdat(32'h304));
    done_q.push_back(3'b100);
    issue(1'b0, 32'h300, 4'hF, 4'd7);
    wait_done("t4_done");
    chk("t4_rd_pulses", 64'(rd_cnt - b_rd), 64'd2);
    chk("t4_cyc_cycles", 64'(cyc_cnt - b_cyc), 64'd3);
    chk_empty("t4");
    err_beat = 99;

    // Silent slave: timeout
    snap();
    no_resp = 1'b1;
    done_q.push_back(3'b110);
    issue(1'b0, 32'h400, 4'hF, 4'd0);
    wait_done("t5_done");
    chk("t5_stb_cycles", 64'(stb_cnt - b_stb), 64'(TMO));
    chk("t5_rd_pulses", 64'(rd_cnt - b_rd), 64'd0);
    chk_empty("t5");
    no_resp = 1'b0;

    // Reset during beat 2 of a read
    snap();
    base_done = done_cnt;
    ack_wait = 3;
    adr_q.push_back(32'h500); rd_q.push_back(rdat(32'h500));
    issue(1'b0, 32'h500, 4'hF, 4'd3);
    begin
      int n = 0;
      while (rd_cnt <= b_rd && n < 100) begin @(negedge wb_clk_i); n++; end
      chk("t6_first_beat", 64'(rd_cnt > b_rd), 64'd1);
    end
    @(posedge wb_clk_i);
    #2 resetn = 1'b0;
    #1 chk_outputs_zero("t6_rst");
    repeat (3) @(negedge wb_clk_i);
    resetn = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    chk("t6_no_done", 64'(done_cnt - base_done), 64'd0);
    chk("t6_ready", 64'(cmd_ready), 64'd1);
    chk_empty("t6");

    // Address wrap at the top of the space
    snap();
    ack_wait = 0;
    adr_q.push_back(32'hFFFFFFFC); adr_q.push_back(32'h0);
    rd_q.push_back(rdat(32'hFFFFFFFC)); rd_q.push_back(rdat(32'h0));
    done_q.push_back(3'b001);
    issue(1'b0, 32'hFFFFFFFC, 4'hF, 4'd1);
    wait_done("t7_done");
    chk("t7_rd_pulses", 64'(rd_cnt - b_rd), 64'd2);
    chk("t7_cyc_cycles", 64'(cyc_cnt - b_cyc), 64'd2);
    chk_empty("t7");

    chk("stb_without_cyc", 64'(viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
